// File: rtl/eth_mac_tx_framer_if.sv
// AXI-Stream bundle carrying serialised frame bytes into the MAC transmit framer.
interface AXIS_IF #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport Sender (output tdata, tvalid, tlast, tuser, input tready);
    modport Receiver (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_mac_tx_framer.sv
// Byte-wide Ethernet MAC transmit framer: preamble/SFD, zero padding, CRC-32 FCS
// and inter-frame gap, driving a registered GMII-style byte interface.
module eth_mac_tx_framer #(
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int IFG_BYTES        = 12,
    parameter bit ENABLE_PADDING   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    AXIS_IF.Receiver   frame_in_if,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       busy,
    output logic       frame_sent,
    output logic       frame_error
);

    // Data bytes required before the FCS; negative means never pad.
    localparam int          PAD_TARGET = MIN_FRAME_LENGTH - 4;
    localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    // IDLE emits the first 0x55, so PREAMBLE covers six more plus the SFD.
    localparam logic [15:0] SFD_PHASE  = 16'd6;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        PAD,
        FCS,
        IFG,
        DRAIN
    } state_t;

    state_t      state, state_next;
    logic [31:0] crc, crc_next;
    logic [15:0] byte_count, byte_count_next, byte_count_inc;
    logic [15:0] phase_count, phase_count_next;
    logic        bad_frame, bad_frame_next;
    logic [31:0] fcs_word;
    logic        ready;
    logic [7:0]  txd_next;
    logic        tx_en_next, tx_er_next, sent_next, error_next;

    function automatic logic [31:0] crc32_next(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign byte_count_inc    = (byte_count == 16'hFFFF) ? byte_count : byte_count + 16'd1;
    assign fcs_word          = bad_frame ? crc : ~crc;
    assign busy              = (state != IDLE);
    assign frame_in_if.tready = ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_next       = state;
        crc_next         = crc;
        byte_count_next  = byte_count;
        phase_count_next = phase_count;
        bad_frame_next   = bad_frame;
        ready            = 1'b0;
        txd_next         = 8'h00;
        tx_en_next       = 1'b0;
        tx_er_next       = 1'b0;
        sent_next        = 1'b0;
        error_next       = 1'b0;

        unique case (state)
            IDLE: begin
                crc_next         = CRC_INIT;
                byte_count_next  = 16'd0;
                phase_count_next = 16'd0;
                bad_frame_next   = 1'b0;
                if (frame_in_if.tvalid) begin
                    txd_next   = 8'h55;
                    tx_en_next = 1'b1;
                    state_next = PREAMBLE;
                end
            end

            PREAMBLE: begin
                tx_en_next = 1'b1;
                if (phase_count == SFD_PHASE) begin
                    txd_next         = 8'hD5;
                    phase_count_next = 16'd0;
                    state_next       = PAYLOAD;
                end else begin
                    txd_next         = 8'h55;
                    phase_count_next = phase_count + 16'd1;
                end
            end

            PAYLOAD: begin
                ready = 1'b1;
                if (frame_in_if.tvalid) begin
                    txd_next        = frame_in_if.tdata;
                    tx_en_next      = 1'b1;
                    crc_next        = crc32_next(crc, frame_in_if.tdata);
                    byte_count_next = byte_count_inc;
                    if (frame_in_if.tlast) begin
                        bad_frame_next = frame_in_if.tuser[0];
                        if (ENABLE_PADDING && (int'(byte_count_inc) < PAD_TARGET)) begin
                            state_next = PAD;
                        end else begin
                            state_next = FCS;
                        end
                    end
                end else begin
                    // Upstream starved mid-frame: poison the wire and abandon the frame.
                    tx_en_next = 1'b1;
                    tx_er_next = 1'b1;
                    error_next = 1'b1;
                    state_next = DRAIN;
                end
            end

            PAD: begin
                tx_en_next      = 1'b1;
                crc_next        = crc32_next(crc, 8'h00);
                byte_count_next = byte_count_inc;
                if (int'(byte_count_inc) >= PAD_TARGET) begin
                    state_next = FCS;
                end
            end

            FCS: begin
                tx_en_next = 1'b1;
                unique case (phase_count[1:0])
                    2'd0: txd_next = fcs_word[7:0];
                    2'd1: txd_next = fcs_word[15:8];
                    2'd2: txd_next = fcs_word[23:16];
                    2'd3: txd_next = fcs_word[31:24];
                endcase
                if (phase_count[1:0] == 2'd3) begin
                    sent_next        = ~bad_frame;
                    error_next       = bad_frame;
                    phase_count_next = 16'd0;
                    state_next       = IFG;
                end else begin
                    phase_count_next = phase_count + 16'd1;
                end
            end

            IFG: begin
                if (int'(phase_count) + 1 >= IFG_BYTES) begin
                    phase_count_next = 16'd0;
                    state_next       = IDLE;
                end else begin
                    phase_count_next = phase_count + 16'd1;
                end
            end

            DRAIN: begin
                ready = 1'b1;
                if (frame_in_if.tvalid && frame_in_if.tlast) begin
                    phase_count_next = 16'd0;
                    state_next       = IFG;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            crc         <= CRC_INIT;
            byte_count  <= 16'd0;
            phase_count <= 16'd0;
            bad_frame   <= 1'b0;
            gmii_txd    <= 8'h00;
            gmii_tx_en  <= 1'b0;
            gmii_tx_er  <= 1'b0;
            frame_sent  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            crc         <= crc_next;
            byte_count  <= byte_count_next;
            phase_count <= phase_count_next;
            bad_frame   <= bad_frame_next;
            gmii_txd    <= txd_next;
            gmii_tx_en  <= tx_en_next;
            gmii_tx_er  <= tx_er_next;
            frame_sent  <= sent_next;
            frame_error <= error_next;
        end
    end

endmodule

// File: doc/eth_mac_tx_framer.md
# eth_mac_tx_framer

- Byte-wide Ethernet MAC transmit framer.
- Sits directly downstream of the Ethernet header/payload serialiser and consumes its 8-bit AXI-Stream frame output (destination MAC through end of payload).
- Adds preamble and SFD, zero-pads short frames to minimum length, computes and appends the CRC-32 FCS, and enforces the inter-frame gap.
- Drives a GMII-style byte interface (`txd`/`tx_en`/`tx_er`) toward the PHY adapter.

## Interface
Parameters:
- `MIN_FRAME_LENGTH`, 64: minimum frame length in bytes, including the FCS and excluding preamble/SFD.
- `IFG_BYTES`, 12: idle byte times inserted after each frame.
- `ENABLE_PADDING`, 1: 1 = zero-pad frames shorter than `MIN_FRAME_LENGTH-4` bytes; 0 = no padding.

Ports (one clock, `clk`; reset `reset` is synchronous and active-high):
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous active-high reset.
- `frame_in_if`  `AXIS_IF.Receiver`  8-bit data, `tuser` 1 bit, no `tkeep`/`tid`/`tdest`  frame bytes. `tuser` set on the `tlast` beat marks the frame bad.
- `gmii_txd`  out  8  transmit byte.
- `gmii_tx_en`  out  1  transmit enable.
- `gmii_tx_er`  out  1  transmit error.
- `busy`  out  1  high in every state except IDLE.
- `frame_sent`  out  1  one-cycle pulse when the last FCS byte is driven on a good frame.
- `frame_error`  out  1  one-cycle pulse on an underflow abort, or when the last FCS byte is driven on a `tuser`-bad frame.

## Operation
- GMII outputs are registered. The state decided in cycle t sets the byte driven at t+1.
- IDLE:
  - `tready`=0.
  - When `tvalid`=1, go to PREAMBLE.
- PREAMBLE: drive 7 bytes of 0x55, then 0xD5 (SFD), with `tx_en`=1. Go to PAYLOAD.
- PAYLOAD:
  - `tready`=1.
  - Each accepted byte is driven and folded into the CRC and the 16-bit saturating byte counter.
  - On an accepted `tlast`: go to PAD if `ENABLE_PADDING` and count < `MIN_FRAME_LENGTH-4`; otherwise go to FCS. Latch `tuser`.
- PAD: drive 0x00 bytes, included in the CRC, until count = `MIN_FRAME_LENGTH-4`. Go to FCS.
- FCS:
  - Drive 4 bytes of ~crc, LSB byte first: crc[7:0], [15:8], [23:16], [31:24].
  - If the latched `tuser`=1, drive the FCS bytes inverted (crc un-complemented), which guarantees a bad FCS.
  - Go to IFG.
- IFG: `tx_en`=0 and `tready`=0 for `IFG_BYTES` cycles, then go to IDLE.
- Underflow: `tvalid`=0 in PAYLOAD before `tlast`:
  - Drive one byte with `txd`=0x00, `tx_en`=1, `tx_er`=1, and pulse `frame_error`.
  - Go to DRAIN.
- DRAIN:
  - `tx_en`=0, `tready`=1.
  - Discard beats up to and including `tlast`, then go to IFG.
- CRC-32:
  - Reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, one byte per cycle, computed combinationally from the registered CRC.
  - Reinitialised in IDLE.
- Outside a frame, `txd` = 0x00 and `tx_er` = 0.

## Timing
- Reset values: `gmii_txd`=0x00, `gmii_tx_en`=0, `gmii_tx_er`=0, `busy`=0, `frame_sent`=0, `frame_error`=0, `tready`=0, state IDLE, CRC=0xFFFFFFFF.
- With `tvalid` first seen in IDLE at cycle T0:
  - 0x55 is driven on T0+1..T0+7.
  - 0xD5 is driven on T0+8.
  - `tready` is first high in cycle T0+8.
  - The first payload byte is driven at T0+9.
- Latency from input handshake to `gmii_txd` is exactly 1 cycle.
- The pipeline never stalls the GMII side: `tx_en` is contiguous from the first preamble byte to the last FCS byte, except on underflow.
- The FCS byte directly follows the last payload or pad byte with no gap.
- `frame_sent`/`frame_error` assert in the same cycle that the last FCS byte appears on `gmii_txd`.
- Byte counter saturates at 0xFFFF; frames of 65535 bytes or more still complete correctly.
- Back-to-back frames: the next preamble starts the cycle after IFG ends, when `tvalid` is high. Minimum spacing between the last FCS byte and the next 0x55 is `IFG_BYTES`+1 cycles.
- Reset mid-frame: `tx_en` is 0 the next cycle, with no IFG and no pulses. The remainder of the partly consumed upstream frame is not drained.

## Test plan
- 14-byte frame (dest FF:FF:FF:FF:FF:FF, src 02:00:00:00:00:01, type 0x0800), padding on -> 72 contiguous `tx_en` cycles (8 preamble/SFD + 14 data + 46 × 0x00 + 4 FCS). FCS matches a software CRC-32, `frame_sent` pulses once, then ≥12 idle cycles.
- Payload ASCII "123456789" with `MIN_FRAME_LENGTH`=0 -> FCS bytes 0x26, 0x39, 0xF4, 0xCB in order; 21 `tx_en` cycles.
- 100-byte frame -> no pad bytes; 112 `tx_en` cycles; `tready` high exactly 100 cycles.
- `tvalid` dropped after 20 payload bytes -> one byte with `tx_er`=1, `frame_error` pulse, the rest discarded through `tlast`, `tx_en` low, and the next frame starts only after IFG.
- `tuser`=1 on `tlast` of a 60-byte frame -> FCS bytes equal the bitwise inverse of the correct FCS, `frame_error` pulses, `frame_sent` does not.
- Two frames with `tvalid` held high back to back -> exactly 12 `tx_en`=0 cycles between them; `reset` pulsed mid-payload -> `tx_en`=0 next cycle and all outputs at reset values.
